// File: rtl/singlecycle_pkg.sv
// Shared definitions for the timer bank.
//   - base address of the bank and byte stride of one channel window
//   - byte offsets of the four registers inside a channel window
//   - CTRL bit positions, packed CTRL struct and a helper that packs it
//     back into a 32-bit bus word
//   - channel state enumeration
package singlecycle_pkg;

    localparam logic [31:0] TIMER_BASE_ADDR = 32'h0000_4000;
    localparam int unsigned TIMER_STRIDE    = 16;

    // Register byte offsets inside one channel window
    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_COMPARE = 4'h4;
    localparam logic [3:0] OFF_COUNT   = 4'h8;
    localparam logic [3:0] OFF_STATUS  = 4'hC;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_MODE_BIT   = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 2;
    localparam int unsigned CTRL_PRESC_LSB  = 8;
    localparam int unsigned CTRL_PRESC_W    = 8;

    typedef struct packed {
        logic [CTRL_PRESC_W-1:0] presc;
        logic                    irq_en;
        logic                    mode;     // 0 one-shot, 1 periodic
        logic                    en;
    } timer_ctrl_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } TimerState_e;

    // Unimplemented CTRL bits read back as zero.
    function automatic logic [31:0] ctrl_to_word(input timer_ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[CTRL_EN_BIT]                        = c.en;
        w[CTRL_MODE_BIT]                      = c.mode;
        w[CTRL_IRQ_EN_BIT]                    = c.irq_en;
        w[CTRL_PRESC_LSB +: CTRL_PRESC_W]     = c.presc;
        return w;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/COMPARE/COUNT/MATCH registers, prescaler and
// IDLE/RUN/EXPIRED state machine.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   wr_ctrl_i .. wr_status_i  one-hot register write strobes (already decoded)
//   wdata_i                bus write data
//   ctrl_o, cmp_o, cnt_o   register contents for the read mux
//   match_o                STATUS.MATCH
//   irq_o                  MATCH gated by IRQ_EN
module timer_channel
    import singlecycle_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_ctrl_i,
    input  logic              wr_cmp_i,
    input  logic              wr_cnt_i,
    input  logic              wr_status_i,
    input  logic [31:0]       wdata_i,
    output timer_ctrl_t       ctrl_o,
    output logic [CNT_W-1:0]  cmp_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              match_o,
    output logic              irq_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    TimerState_e       state_q, state_d;
    timer_ctrl_t       ctrl_q, ctrl_d, wr_ctrl_val;
    logic [CNT_W-1:0]  cmp_q, cmp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        presc_q, presc_d;
    logic              match_q, match_d;

    logic              running;
    logic              tick;
    logic              en_rise;
    logic              unused_wdata;

    assign wr_ctrl_val.en     = wdata_i[CTRL_EN_BIT];
    assign wr_ctrl_val.mode   = wdata_i[CTRL_MODE_BIT];
    assign wr_ctrl_val.irq_en = wdata_i[CTRL_IRQ_EN_BIT];
    assign wr_ctrl_val.presc  = wdata_i[CTRL_PRESC_LSB +: CTRL_PRESC_W];
    assign unused_wdata       = ^{wdata_i[31:16], wdata_i[7:3]};

    assign running = (state_q == RUN);
    assign tick    = running && (presc_q == ctrl_q.presc);
    assign en_rise = wr_ctrl_i && wr_ctrl_val.en && !ctrl_q.en;

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        match_d = match_q;

        // Hardware update first; software writes below override it.
        if (running) begin
            presc_d = tick ? 8'd0 : presc_q + 8'd1;
        end
        if (tick) begin
            if (cnt_q == cmp_q) begin
                if (ctrl_q.mode) begin
                    cnt_d = '0;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = EXPIRED;
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // W1C clear is applied before the hardware set so a same-cycle
        // match survives the clear.
        if (wr_status_i && wdata_i[0]) begin
            match_d = 1'b0;
        end
        if (tick && (cnt_q == cmp_q)) begin
            match_d = 1'b1;
        end

        if (wr_cmp_i) begin
            cmp_d = wdata_i[CNT_W-1:0];
        end
        if (wr_cnt_i) begin
            cnt_d   = wdata_i[CNT_W-1:0];
            presc_d = 8'd0;
        end
        if (wr_ctrl_i) begin
            ctrl_d = wr_ctrl_val;
            if (en_rise) begin
                state_d = RUN;
                presc_d = 8'd0;
            end else if (wr_ctrl_val.en) begin
                // EN rewritten as 1 while running: keep running even if a
                // one-shot match tried to expire the channel this cycle.
                state_d = state_q;
            end else if (state_q == RUN) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            cmp_q   <= '0;
            cnt_q   <= '0;
            presc_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
            match_q <= match_d;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign cmp_o   = cmp_q;
    assign cnt_o   = cnt_q;
    assign match_o = match_q;
    assign irq_o   = match_q && ctrl_q.irq_en;

endmodule

// File: rtl/timer_bank.sv
// Bank of N_TIMERS memory-mapped timer channels with per-channel interrupts.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_lsu_valid      bus access valid this cycle
//   i_addr           byte address (bits [1:0] ignored)
//   i_wen, i_wdata   write enable and data
//   o_rdata          combinational read data (0 when not a valid hit)
//   o_hit            address falls inside the bank window
//   o_irq            per-channel level interrupt
//   o_irq_any        OR of o_irq
module timer_bank
    import singlecycle_pkg::*;
#(
    parameter int unsigned N_TIMERS  = 4,
    parameter int unsigned CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = TIMER_BASE_ADDR
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_lsu_valid,
    input  logic [31:0]         i_addr,
    input  logic                i_wen,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_rdata,
    output logic                o_hit,
    output logic [N_TIMERS-1:0] o_irq,
    output logic                o_irq_any
);

    localparam logic [31:0] WIN_BYTES = 32'(TIMER_STRIDE * N_TIMERS);

    logic [31:0]       offset;
    logic [2:0]        chan_idx;
    logic [3:0]        reg_off;
    logic              wr_access;

    timer_ctrl_t       ch_ctrl  [N_TIMERS];
    logic [CNT_W-1:0]  ch_cmp   [N_TIMERS];
    logic [CNT_W-1:0]  ch_cnt   [N_TIMERS];
    logic [N_TIMERS-1:0] ch_match;

    // Unsigned subtraction: addresses below the base wrap to a huge offset
    // and fail the window compare, so one compare covers both bounds.
    assign offset    = i_addr - BASE_ADDR;
    assign o_hit     = (offset < WIN_BYTES);
    assign chan_idx  = offset[6:4];
    assign reg_off   = {offset[3:2], 2'b00};
    assign wr_access = i_lsu_valid && i_wen && o_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N_TIMERS; gi++) begin : g_ch
            logic ch_sel;
            assign ch_sel = wr_access && (chan_idx == 3'(gi));

            timer_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk_i       (i_clk),
                .rst_ni      (i_rst_n),
                .wr_ctrl_i   (ch_sel && (reg_off == OFF_CTRL)),
                .wr_cmp_i    (ch_sel && (reg_off == OFF_COMPARE)),
                .wr_cnt_i    (ch_sel && (reg_off == OFF_COUNT)),
                .wr_status_i (ch_sel && (reg_off == OFF_STATUS)),
                .wdata_i     (i_wdata),
                .ctrl_o      (ch_ctrl[gi]),
                .cmp_o       (ch_cmp[gi]),
                .cnt_o       (ch_cnt[gi]),
                .match_o     (ch_match[gi]),
                .irq_o       (o_irq[gi])
            );
        end
    endgenerate

    always_comb begin
        o_rdata = '0;
        if (i_lsu_valid && o_hit) begin
            for (int i = 0; i < int'(N_TIMERS); i++) begin
                if (chan_idx == 3'(i)) begin
                    case (reg_off)
                        OFF_CTRL:    o_rdata = ctrl_to_word(ch_ctrl[i]);
                        OFF_COMPARE: o_rdata = 32'(ch_cmp[i]);
                        OFF_COUNT:   o_rdata = 32'(ch_cnt[i]);
                        default:     o_rdata = {31'b0, ch_match[i]};
                    endcase
                end
            end
        end
    end

    assign o_irq_any = |o_irq;

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;

    logic [31:0] rdata, rdata8;
    logic        hit, hit8;
    logic [N-1:0] irq, irq8;
    logic        irq_any, irq_any8;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int last_wr_edge = 0;

    timer_bank #(.N_TIMERS(N), .CNT_W(32), .BASE_ADDR(32'h0000_4000)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lsu_valid(valid), .i_addr(addr),
        .i_wen(wen), .i_wdata(wdata), .o_rdata(rdata), .o_hit(hit),
        .o_irq(irq), .o_irq_any(irq_any)
    );

    // 8-bit counter instance on its own address range, sharing the bus.
    timer_bank #(.N_TIMERS(N), .CNT_W(8), .BASE_ADDR(32'h0000_8000)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_lsu_valid(valid), .i_addr(addr),
        .i_wen(wen), .i_wdata(wdata), .o_rdata(rdata8), .o_hit(hit8),
        .o_irq(irq8), .o_irq_any(irq_any8)
    );

    always #50 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called in the low clock phase; returns at the following negedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1; wen = 1'b1; addr = a; wdata = d;
        last_wr_edge = edge_cnt + 1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; wen = 1'b0;
        $display("wr  addr=0x%08h data=0x%08h edge=%0d", a, d, last_wr_edge);
    endtask

    task automatic rd(input bit use8, input logic [31:0] a, output logic [31:0] d);
        valid = 1'b1; wen = 1'b0; addr = a;
        #1;
        d = use8 ? rdata8 : rdata;
        valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    typedef struct {
        bit          v;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        bit          exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[16];

    int          cmp_r[N], presc_r[N], mode_r[N], ie_r[N], e0_r[N];
    logic [31:0] ctrl_r[N];

    initial begin
        logic [31:0] d;
        int k, exp_cnt, exp_m, exp_en;
        logic [N-1:0] exp_irq;

        // ---------------- reset state ----------------
        @(negedge clk);
        rd(0, 32'h4000, d); check("reset_ctrl0", d, 32'h0);
        rd(0, 32'h4008, d); check("reset_count0", d, 32'h0);
        check("reset_irq", {28'b0, irq}, 32'h0);
        check("reset_irq_any", {31'b0, irq_any}, 32'h0);
        rst_n = 1'b1;
        step(1);

        // ---------------- decode / register table ----------------
        vecs[0]  = '{1, 1, 32'h4010, 32'h0000_FF06, 1, 32'h0};
        vecs[1]  = '{1, 0, 32'h4010, 32'h0,         1, 32'h0000_FF06};
        vecs[2]  = '{1, 1, 32'h4010, 32'hFFFF_FFF8, 1, 32'h0};
        vecs[3]  = '{1, 0, 32'h4010, 32'h0,         1, 32'h0000_FF00};
        vecs[4]  = '{1, 1, 32'h4024, 32'hDEAD_BEEF, 1, 32'h0};
        vecs[5]  = '{1, 0, 32'h4024, 32'h0,         1, 32'hDEAD_BEEF};
        vecs[6]  = '{1, 0, 32'h4026, 32'h0,         1, 32'hDEAD_BEEF};
        vecs[7]  = '{1, 1, 32'h4038, 32'h1234_5678, 1, 32'h0};
        vecs[8]  = '{1, 0, 32'h4038, 32'h0,         1, 32'h1234_5678};
        vecs[9]  = '{1, 0, 32'h4040, 32'h0,         0, 32'h0};
        vecs[10] = '{1, 1, 32'h4040, 32'h0000_FFFF, 0, 32'h0};
        vecs[11] = '{1, 0, 32'h4000, 32'h0,         1, 32'h0};
        vecs[12] = '{1, 0, 32'h3FFC, 32'h0,         0, 32'h0};
        vecs[13] = '{0, 0, 32'h4024, 32'h0,         1, 32'h0};
        vecs[14] = '{1, 0, 32'h402C, 32'h0,         1, 32'h0};
        vecs[15] = '{1, 0, 32'h403C, 32'h0,         1, 32'h0};

        for (int i = 0; i < 16; i++) begin
            valid = vecs[i].v; wen = vecs[i].w; addr = vecs[i].a; wdata = vecs[i].d;
            #1;
            check($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
            if (!vecs[i].w) begin
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            end
            $display("vec %0d v=%0d w=%0d addr=0x%08h hit=%0d rdata=0x%08h",
                     i, vecs[i].v, vecs[i].w, vecs[i].a, hit, rdata);
            if (vecs[i].w) begin
                @(posedge clk);
                @(negedge clk);
            end
            valid = 1'b0; wen = 1'b0;
        end

        // ---------------- periodic run ----------------
        do_reset();
        wr(32'h4004, 32'd3);
        wr(32'h4000, 32'h7);
        for (int j = 1; j <= 8; j++) begin
            step(1);
            rd(0, 32'h4008, d);
            check($sformatf("periodic_count_e%0d", j), d, 32'(j % 4));
            check($sformatf("periodic_irq0_e%0d", j), {31'b0, irq[0]}, {31'b0, (j >= 4)});
        end
        check("periodic_irq_any", {31'b0, irq_any}, 32'h1);

        // ---------------- one-shot with prescaler ----------------
        do_reset();
        wr(32'h4014, 32'd2);
        wr(32'h4010, 32'h105);
        for (int j = 1; j <= 10; j++) begin
            step(1);
            exp_cnt = (j < 2) ? 0 : (j < 4) ? 1 : 2;
            rd(0, 32'h4018, d); check($sformatf("oneshot_count_e%0d", j), d, 32'(exp_cnt));
            rd(0, 32'h401C, d); check($sformatf("oneshot_match_e%0d", j), d, {31'b0, (j >= 6)});
            rd(0, 32'h4010, d); check($sformatf("oneshot_ctrl_e%0d", j), d, (j >= 6) ? 32'h104 : 32'h105);
            check($sformatf("oneshot_irq1_e%0d", j), {31'b0, irq[1]}, {31'b0, (j >= 6)});
        end
        // Re-enable from EXPIRED: runs again, then expires on the first tick.
        wr(32'h4010, 32'h105);
        rd(0, 32'h4010, d); check("rearm_ctrl_running", d, 32'h105);
        step(2);
        rd(0, 32'h4010, d); check("rearm_ctrl_expired", d, 32'h104);
        rd(0, 32'h4018, d); check("rearm_count_hold", d, 32'd2);

        // ---------------- W1C race ----------------
        do_reset();
        wr(32'h4004, 32'd3);
        wr(32'h4000, 32'h7);
        step(3);
        wr(32'h400C, 32'h1);            // lands on the matching edge
        rd(0, 32'h400C, d); check("w1c_race_match", d, 32'h1);
        check("w1c_race_irq", {31'b0, irq[0]}, 32'h1);
        wr(32'h400C, 32'h0);
        rd(0, 32'h400C, d); check("w1c_zero_noeffect", d, 32'h1);
        wr(32'h400C, 32'h1);
        rd(0, 32'h400C, d); check("w1c_clear", d, 32'h0);
        check("w1c_irq_drop", {31'b0, irq[0]}, 32'h0);

        // ---------------- 8-bit wrap ----------------
        do_reset();
        wr(32'h8008, 32'd10);
        wr(32'h8004, 32'd5);
        wr(32'h8000, 32'h1);
        step(245);
        rd(1, 32'h8008, d); check("wrap_count_255", d, 32'd255);
        rd(1, 32'h800C, d); check("wrap_nomatch_255", d, 32'h0);
        step(1);
        rd(1, 32'h8008, d); check("wrap_count_0", d, 32'd0);
        rd(1, 32'h800C, d); check("wrap_nomatch_0", d, 32'h0);
        step(5);
        rd(1, 32'h8008, d); check("wrap_count_5", d, 32'd5);
        rd(1, 32'h800C, d); check("wrap_nomatch_5", d, 32'h0);
        step(1);
        rd(1, 32'h800C, d); check("wrap_match", d, 32'h1);
        rd(1, 32'h8008, d); check("wrap_count_hold", d, 32'd5);
        rd(1, 32'h8000, d); check("wrap_ctrl_en_clear", d, 32'h0);

        // ---------------- reset mid-run ----------------
        do_reset();
        wr(32'h4004, 32'd1);
        wr(32'h4000, 32'h7);
        wr(32'h4024, 32'd100);
        wr(32'h4020, 32'h1);
        step(7);
        rd(0, 32'h4028, d); check("midrst_count_before", d, 32'd7);
        check("midrst_irq_before", {31'b0, irq[0]}, 32'h1);
        rst_n = 1'b0;
        #1;
        rd(0, 32'h4028, d); check("midrst_count_async", d, 32'h0);
        rd(0, 32'h4020, d); check("midrst_ctrl_async", d, 32'h0);
        check("midrst_irq_async", {28'b0, irq}, 32'h0);
        check("midrst_irq_any_async", {31'b0, irq_any}, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(5);
        rd(0, 32'h4028, d); check("midrst_count_after", d, 32'h0);
        rd(0, 32'h4020, d); check("midrst_ctrl_after", d, 32'h0);
        rd(0, 32'h4000, d); check("midrst_ctrl0_after", d, 32'h0);

        // ---------------- randomized run vs. closed-form model ----------------
        do_reset();
        for (int i = 0; i < N; i++) begin
            cmp_r[i]   = int'($urandom_range(0, 12));
            presc_r[i] = int'($urandom_range(0, 3));
            mode_r[i]  = int'($urandom_range(0, 1));
            ie_r[i]    = int'($urandom_range(0, 1));
            ctrl_r[i]  = 32'h1 | (32'(mode_r[i]) << 1) | (32'(ie_r[i]) << 2) | (32'(presc_r[i]) << 8);
            wr(32'h4004 + 32'(16 * i), 32'(cmp_r[i]));
            wr(32'h4000 + 32'(16 * i), ctrl_r[i]);
            e0_r[i] = last_wr_edge;
        end
        for (int s = 0; s < 25; s++) begin
            step(int'($urandom_range(1, 6)));
            exp_irq = '0;
            for (int i = 0; i < N; i++) begin
                // k = number of prescaler ticks since the enabling edge
                k = (edge_cnt - e0_r[i]) / (presc_r[i] + 1);
                if (mode_r[i] != 0) begin
                    exp_cnt = k % (cmp_r[i] + 1);
                    exp_m   = (k >= cmp_r[i] + 1) ? 1 : 0;
                    exp_en  = 1;
                end else begin
                    exp_cnt = (k < cmp_r[i]) ? k : cmp_r[i];
                    exp_m   = (k >= cmp_r[i] + 1) ? 1 : 0;
                    exp_en  = 1 - exp_m;
                end
                exp_irq[i] = (exp_m != 0) && (ie_r[i] != 0);
                rd(0, 32'h4008 + 32'(16 * i), d);
                check($sformatf("rand_s%0d_ch%0d_count", s, i), d, 32'(exp_cnt));
                rd(0, 32'h400C + 32'(16 * i), d);
                check($sformatf("rand_s%0d_ch%0d_match", s, i), d, 32'(exp_m));
                rd(0, 32'h4000 + 32'(16 * i), d);
                check($sformatf("rand_s%0d_ch%0d_ctrl", s, i), d,
                      (exp_en != 0) ? ctrl_r[i] : (ctrl_r[i] & 32'hFFFF_FFFE));
            end
            check($sformatf("rand_s%0d_irq", s), {28'b0, irq}, {28'b0, exp_irq});
            $display("sample %0d edge=%0d irq=%b", s, edge_cnt, irq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter N_TIMERS, default 4: number of independent timer channels, legal range 1-8.
REQ-002 SHALL have parameter CNT_W, default 32: counter and compare width in bits, legal range 8-32.
REQ-003 SHALL have parameter BASE_ADDR, default TIMER_BASE_ADDR (0x0000_4000): byte address of channel 0.
REQ-004 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_lsu_valid, input, 1 bit: the bus access in this cycle is valid.
REQ-007 SHALL have port i_addr, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-008 SHALL have port i_wen, input, 1 bit: write when high, read when low.
REQ-009 SHALL have port i_wdata, input, 32 bits: write data.
REQ-010 SHALL have port o_rdata, output, 32 bits: read data, combinational in the same cycle.
REQ-011 SHALL have port o_hit, output, 1 bit: i_addr falls in [BASE_ADDR, BASE_ADDR + 16*N_TIMERS).
REQ-012 SHALL have port o_irq, output, N_TIMERS bits: per-channel interrupt, level-sensitive.
REQ-013 SHALL have port o_irq_any, output, 1 bit: OR of all o_irq bits.

Function
REQ-014 SHALL give each channel a 16-byte register window: CTRL at +0x0, COMPARE at +0x4, COUNT at +0x8, STATUS at +0xC.
REQ-015 SHALL define CTRL bits as: [0] EN, [1] MODE (0 one-shot, 1 periodic), [2] IRQ_EN, [15:8] PRESC; all other bits read 0.
REQ-016 SHALL implement STATUS[0] as MATCH, write-1-to-clear; writing 0 has no effect.
REQ-017 SHALL perform a register write only when i_lsu_valid, i_wen and o_hit are all high.
REQ-018 SHALL return 0 in o_rdata for any read outside the window or with i_lsu_valid low.
REQ-019 SHALL truncate COMPARE/COUNT writes to CNT_W bits and zero-extend them on read.
REQ-020 SHALL run a per-channel state machine with states IDLE, RUN and EXPIRED:
- IDLE to RUN: on an EN 0->1 write.
- RUN to IDLE: on an EN=0 write.
- RUN to EXPIRED: on a one-shot match.
- EXPIRED to RUN: on an EN 0->1 write.
REQ-021 SHALL, in RUN, increment an 8-bit prescaler each cycle and assert tick when prescaler==PRESC, then clear it.
- COUNT advances once per PRESC+1 cycles.
- First increment occurs PRESC+1 edges after the enabling write edge.
REQ-022 SHALL, on tick with COUNT==COMPARE:
- set MATCH;
- periodic mode: load COUNT with 0, giving period (COMPARE+1)*(PRESC+1) cycles;
- one-shot mode: hold COUNT, clear EN, enter EXPIRED.
REQ-023 SHALL, on tick with COUNT!=COMPARE, increment COUNT modulo 2^CNT_W without setting MATCH (a COMPARE written below COUNT causes a wrap before the match).
REQ-024 SHALL clear the prescaler on an EN 0->1 write or any COUNT write; a CTRL write with EN already 1 SHALL NOT disturb the prescaler.
REQ-025 SHALL give a same-cycle software COUNT/CTRL write priority over the hardware update.
REQ-026 SHALL give a same-cycle hardware MATCH set priority over a software W1C clear.
REQ-027 SHALL drive o_irq[i] = MATCH[i] AND IRQ_EN[i], combinationally from registered state.

Reset
REQ-028 SHALL, while i_rst_n is low, asynchronously force every channel to IDLE and clear CTRL, COMPARE, COUNT, prescaler and MATCH; o_irq and o_irq_any SHALL be 0.
REQ-029 SHALL, on reset mid-count, discard all progress; counting resumes only after a new EN write.

Structure
REQ-030 SHALL place the following in singlecycle_pkg: register offsets, TIMER_STRIDE (16), CTRL bit positions, a packed CTRL struct, and an enum TimerState_e for IDLE/RUN/EXPIRED.
REQ-031 SHALL implement one sub-module, timer_channel, instantiated N_TIMERS times by generate; address decode and read mux SHALL stay in timer_bank.

Verification
REQ-032 Periodic run: COMPARE=3, PRESC=0, CTRL=0x7 -> MATCH/o_irq[0] high 4 cycles after enable; COUNT sequence 1,2,3,0; period 4 cycles.
REQ-033 One-shot with prescaler: COMPARE=2, PRESC=1, CTRL=0x105 -> match at edge 6; EN reads 0; COUNT holds 2; state EXPIRED.
REQ-034 W1C race: STATUS write 0x1 in the same cycle as a match -> MATCH stays 1; a later write 0x1 clears it and o_irq drops next cycle.
REQ-035 Wrap: CNT_W=8, COUNT=10, COMPARE=5 -> COUNT passes 255 -> 0 with no MATCH, then MATCH at 5.
REQ-036 Reset mid-run: i_rst_n low while COUNT=7 -> COUNT, CTRL and o_irq read 0 immediately; no increments after release.
REQ-037 Decode: N_TIMERS=4 -> access at 0x4040 gives o_hit=0 and rdata=0; 0x4038 reads channel 3 COUNT.
